// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one single-port data memory between two requesters:
//   port 0 = core load/store unit, port 1 = DMA/debug loader.
// Arbitration is round-robin per access. A port may keep ownership across a
// burst by asserting its lock input, but ownership is bounded by LOCK_MAX
// owned cycles.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   pN_req/we/lock/addr/wdata     requester N access request (N = 0, 1)
//   pN_gnt                        access accepted this cycle (combinational)
//   pN_rvalid/rdata               read return, one cycle after the grant
//   pN_err                        pulse: previous granted access was out of range
//   mem_we/mem_addr/mem_wd        memory write enable, address, write data
//   mem_rd                        memory combinational read data
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int DEPTH    = 256,
    parameter int LOCK_MAX = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic          p0_lock,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    output logic          p0_err,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic          p1_lock,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic          p1_err,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    localparam int CW = $clog2(LOCK_MAX + 1);
    // One extra bit so DEPTH is representable even when it equals 2**AW.
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state_reg;
    logic          last_gnt_reg;
    logic [CW-1:0] lock_cnt_reg;

    // Per-port views of the two requester interfaces (index 0 = port 0).
    logic [1:0]         req;
    logic [1:0]         we;
    logic [1:0]         lock;
    logic [1:0]         gnt;
    logic [1:0]         in_range;
    logic [1:0][AW-1:0] addr;
    logic [1:0][DW-1:0] wdata;
    logic [1:0]         rvalid;
    logic [1:0]         err;
    logic [1:0][DW-1:0] rdata;
    logic               own;

    assign req   = {p1_req, p0_req};
    assign we    = {p1_we, p0_we};
    assign lock  = {p1_lock, p0_lock};
    assign addr  = {p1_addr, p0_addr};
    assign wdata = {p1_wdata, p0_wdata};
    assign own   = (state_reg == OWN1);

    assign p0_gnt    = gnt[0];
    assign p1_gnt    = gnt[1];
    assign p0_rvalid = rvalid[0];
    assign p1_rvalid = rvalid[1];
    assign p0_err    = err[0];
    assign p1_err    = err[1];
    assign p0_rdata  = rdata[0];
    assign p1_rdata  = rdata[1];

    // Grant decision. While a port owns the bus the other one simply stalls;
    // a release only takes effect from the next cycle on.
    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            case (state_reg)
                IDLE: begin
                    if (&req) begin
                        gnt = last_gnt_reg ? 2'b01 : 2'b10;
                    end else begin
                        gnt = req;
                    end
                end
                OWN0:    gnt = {1'b0, req[0]};
                OWN1:    gnt = {req[1], 1'b0};
                default: gnt = 2'b00;
            endcase
        end
    end

    // Memory drive: the granted port's address/data, zero when nobody is
    // granted. Out-of-range writes are consumed but never reach the memory.
    always_comb begin
        mem_we   = |(gnt & we & in_range);
        mem_addr = '0;
        mem_wd   = '0;
        if (gnt[1]) begin
            mem_addr = addr[1];
            mem_wd   = wdata[1];
        end else if (gnt[0]) begin
            mem_addr = addr[0];
            mem_wd   = wdata[0];
        end
    end

    // Arbitration / lock state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            last_gnt_reg <= 1'b1;
            lock_cnt_reg <= '0;
        end else begin
            if (gnt[0]) begin
                last_gnt_reg <= 1'b0;
            end else if (gnt[1]) begin
                last_gnt_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (gnt[0] && lock[0]) begin
                        state_reg    <= OWN0;
                        lock_cnt_reg <= CW'(1);
                    end else if (gnt[1] && lock[1]) begin
                        state_reg    <= OWN1;
                        lock_cnt_reg <= CW'(1);
                    end
                end
                OWN0, OWN1: begin
                    // The owner's access in the timeout cycle is still granted
                    // above; ownership ends at this edge. last_gnt points at the
                    // owner so the other port wins the next contention.
                    if (!req[own] || !lock[own] || lock_cnt_reg == CW'(LOCK_MAX)) begin
                        state_reg    <= IDLE;
                        last_gnt_reg <= own;
                        lock_cnt_reg <= '0;
                    end else if (lock_cnt_reg != CW'(LOCK_MAX)) begin
                        lock_cnt_reg <= lock_cnt_reg + CW'(1);
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    lock_cnt_reg <= '0;
                end
            endcase
        end
    end

    // Per-port registered read return and range error.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic          rvalid_reg;
            logic          err_reg;
            logic [DW-1:0] rdata_reg;

            assign in_range[gi] = {1'b0, addr[gi]} < DEPTH_W;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rvalid_reg <= 1'b0;
                    err_reg    <= 1'b0;
                    rdata_reg  <= '0;
                end else begin
                    rvalid_reg <= gnt[gi] && !we[gi];
                    err_reg    <= gnt[gi] && !in_range[gi];
                    // Out-of-range reads return zero rather than whatever the
                    // memory drives; rdata otherwise holds between returns.
                    if (gnt[gi] && !we[gi]) begin
                        rdata_reg <= in_range[gi] ? mem_rd : '0;
                    end
                end
            end

            assign rvalid[gi] = rvalid_reg;
            assign err[gi]    = err_reg;
            assign rdata[gi]  = rdata_reg;
        end
    endgenerate

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios followed by random traffic.
// A driver issues one cycle of stimulus at a time, checks grants and memory
// drive against a reference model, and queues the expected read/error
// responses; a separate monitor pops and compares them as the DUT returns them.
module tb_dmem_arbiter;

    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int DEPTH    = 256;
    localparam int LOCK_MAX = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          p0_req, p0_we, p0_lock;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic          p0_gnt, p0_rvalid, p0_err;
    logic [DW-1:0] p0_rdata;
    logic          p1_req, p1_we, p1_lock;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          p1_gnt, p1_rvalid, p1_err;
    logic [DW-1:0] p1_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
        .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
        .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    // Environment memory attached to the DUT (combinational read, clocked write).
    logic [DW-1:0] env_mem [DEPTH];
    assign mem_rd = (mem_addr < DEPTH) ? env_mem[mem_addr[7:0]] : 32'hDEAD_BEEF;
    always @(posedge clk) begin
        if (mem_we && mem_addr < DEPTH) env_mem[mem_addr[7:0]] <= mem_wd;
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [DEPTH];
    int m_owner = -1;   // -1: nobody owns the bus
    int m_last  = 1;
    int m_owned = 0;    // owned cycles so far in the current lock

    typedef struct {
        int            due;
        bit            is_read;
        bit            err;
        logic [DW-1:0] data;
    } resp_t;
    resp_t q0[$];
    resp_t q1[$];
    logic [DW-1:0] held [2];

    int checks   = 0;
    int failures = 0;
    int ncyc     = 0;

    always @(negedge clk) ncyc <= ncyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, ncyc, act, exp);
        end
    endtask

    // One bus cycle: drive, check grant and memory drive, advance the model.
    task automatic cycle(input bit r, input bit [1:0] req, input bit [1:0] we,
                         input bit [1:0] lk, input logic [AW-1:0] a0,
                         input logic [AW-1:0] a1, input logic [DW-1:0] d0,
                         input logic [DW-1:0] d1);
        int g;
        logic [AW-1:0] a [2];
        logic [DW-1:0] d [2];
        logic [1:0] exp_gnt;
        resp_t e;
        a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
        @(negedge clk);
        #1;
        rst = r;
        p0_req = req[0]; p0_we = we[0]; p0_lock = lk[0]; p0_addr = a0; p0_wdata = d0;
        p1_req = req[1]; p1_we = we[1]; p1_lock = lk[1]; p1_addr = a1; p1_wdata = d1;
        #1;
        // Who should be granted this cycle.
        g = -1;
        if (!r) begin
            if (m_owner >= 0) begin
                if (req[m_owner]) g = m_owner;
            end else if (req == 2'b11) begin
                g = 1 - m_last;
            end else if (req[0]) begin
                g = 0;
            end else if (req[1]) begin
                g = 1;
            end
        end
        exp_gnt = 2'b00;
        if (g >= 0) exp_gnt[g] = 1'b1;
        $display("cyc=%0d rst=%0b req=%b we=%b lock=%b exp_gnt=%b gnt=%b", ncyc, r, req, we, lk,
                 exp_gnt, {p1_gnt, p0_gnt});
        check("gnt", {62'd0, p1_gnt, p0_gnt}, {62'd0, exp_gnt});
        if (g >= 0) begin
            check("mem_we", {63'd0, mem_we}, {63'd0, (we[g] && a[g] < DEPTH)});
            check("mem_addr", {32'd0, mem_addr}, {32'd0, a[g]});
            check("mem_wd", {32'd0, mem_wd}, {32'd0, d[g]});
        end else begin
            check("mem_idle", {31'd0, mem_we, mem_addr}, 64'd0);
        end
        @(posedge clk);
        if (r) begin
            m_owner = -1; m_last = 1; m_owned = 0;
            q0.delete(); q1.delete();
            held[0] = '0; held[1] = '0;
        end else begin
            if (g >= 0) begin
                e.due = ncyc + 1;
                e.is_read = !we[g];
                e.err = (a[g] >= DEPTH);
                e.data = (!we[g] && a[g] < DEPTH) ? ref_mem[a[g][7:0]] : '0;
                if (e.is_read || e.err) begin
                    if (g == 0) q0.push_back(e); else q1.push_back(e);
                end
                if (we[g] && a[g] < DEPTH) ref_mem[a[g][7:0]] = d[g];
            end
            if (m_owner < 0) begin
                if (g >= 0 && lk[g]) begin
                    m_owner = g;
                    m_owned = 1;
                end
            end else if (!req[m_owner] || !lk[m_owner] || m_owned == LOCK_MAX) begin
                m_owner = -1;
            end else begin
                m_owned++;
            end
            if (g >= 0) m_last = g;
        end
    endtask

    // Monitor: compares read returns and error pulses against the queues.
    task automatic mon_port(input int p, input logic rv, input logic er, input logic [DW-1:0] rd);
        resp_t e;
        bit hit;
        hit = 1'b0;
        if (p == 0 && q0.size() > 0 && q0[0].due == ncyc) begin e = q0.pop_front(); hit = 1'b1; end
        if (p == 1 && q1.size() > 0 && q1[0].due == ncyc) begin e = q1.pop_front(); hit = 1'b1; end
        if (hit) begin
            $display("cyc=%0d port%0d resp rvalid=%0b err=%0b rdata=%0h exp_read=%0b exp_err=%0b exp_data=%0h",
                     ncyc, p, rv, er, rd, e.is_read, e.err, e.data);
            check($sformatf("rvalid%0d", p), {63'd0, rv}, {63'd0, e.is_read});
            check($sformatf("err%0d", p), {63'd0, er}, {63'd0, e.err});
            if (e.is_read) held[p] = e.data;
        end else begin
            check($sformatf("quiet%0d", p), {62'd0, rv, er}, 64'd0);
        end
        check($sformatf("rdata%0d", p), {32'd0, rd}, {32'd0, held[p]});
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            mon_port(0, p0_rvalid, p0_err, p0_rdata);
            mon_port(1, p1_rvalid, p1_err, p1_rdata);
        end
    end

    initial begin
        logic [AW-1:0] ra0, ra1;
        held[0] = '0; held[1] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            env_mem[i] = 32'h100 + i;
            ref_mem[i] = 32'h100 + i;
        end
        env_mem[3] = 32'hA; ref_mem[3] = 32'hA;
        env_mem[5] = 32'hB; ref_mem[5] = 32'hB;
        rst = 1'b1;
        p0_req = 1'b1; p0_we = 1'b0; p0_lock = 1'b0; p0_addr = 3; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_lock = 1'b0; p1_addr = 5; p1_wdata = '0;

        // 1: reset with p0 requesting, then p0 granted first.
        for (int i = 0; i < 3; i++) cycle(1, 2'b01, 2'b00, 2'b00, 3, 5, 0, 0);
        cycle(0, 2'b01, 2'b00, 2'b00, 3, 5, 0, 0);
        // 2: both read every cycle -> alternation.
        for (int i = 0; i < 8; i++) cycle(0, 2'b11, 2'b00, 2'b00, 3, 5, 0, 0);
        // 3: p1 locked write burst while p0 keeps requesting, then p0 reads back.
        cycle(0, 2'b01, 2'b00, 2'b00, 3, 5, 0, 0);
        for (int i = 0; i < 4; i++)
            cycle(0, 2'b11, 2'b10, (i < 3) ? 2'b10 : 2'b00, 3, 8 + i, 0, 32'h1234 + i);
        cycle(0, 2'b01, 2'b00, 2'b00, 11, 0, 0, 0);
        cycle(0, 2'b01, 2'b00, 2'b00, 8, 0, 0, 0);
        // 4: p1 holds lock past LOCK_MAX.
        cycle(0, 2'b01, 2'b00, 2'b00, 3, 5, 0, 0);
        for (int i = 0; i < LOCK_MAX + 6; i++) cycle(0, 2'b11, 2'b00, 2'b10, 3, 5, 0, 0);
        // 5: out-of-range write then read.
        cycle(0, 2'b01, 2'b01, 2'b00, 300, 0, 32'h5555, 0);
        cycle(0, 2'b01, 2'b00, 2'b00, 300, 0, 0, 0);
        cycle(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        // 6: reset right after a granted read.
        cycle(0, 2'b01, 2'b00, 2'b00, 5, 0, 0, 0);
        cycle(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        cycle(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        cycle(0, 2'b11, 2'b00, 2'b00, 3, 5, 0, 0);
        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            ra0 = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(250, 300)) : AW'($urandom_range(0, 15));
            ra1 = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(250, 300)) : AW'($urandom_range(0, 15));
            cycle(($urandom_range(0, 99) == 0), 2'($urandom_range(0, 3) | $urandom_range(0, 3)),
                  2'($urandom), 2'($urandom_range(0, 3) | $urandom_range(0, 3)),
                  ra0, ra1, $urandom, $urandom);
        end
        cycle(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        cycle(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        @(negedge clk);
        #2;
        check("drain", 64'(q0.size() + q1.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
